// File: rtl/synth_pkg.sv
// Shared definitions for the note-command decoder and voice allocator:
// command word field positions, voice limits and the decoded command kind.
package synth_pkg;

  localparam int unsigned ON_BIT     = 15;
  localparam int unsigned NOTE_MSB   = 14;
  localparam int unsigned NOTE_LSB   = 8;
  localparam int unsigned VEL_MSB    = 7;
  localparam int unsigned VEL_LSB    = 0;
  localparam int unsigned STOP_ALL_N = 127;
  localparam int unsigned MAX_VOICES = 16;

  // Index and age widths are sized for MAX_VOICES so they never change with NUM_VOICES.
  localparam int unsigned IDX_W = 4;
  localparam int unsigned AGE_W = 4;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_ON,
    CMD_OFF,
    CMD_STOP_ALL
  } cmd_e;

  // Saturating age increment; lim is the oldest representable age for the voice count in use.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age,
                                               input logic [AGE_W-1:0] lim);
    return (age < lim) ? age + 1'b1 : lim;
  endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational voice search: finds the voice already gated with the incoming
// note, the lowest-index free voice, and the oldest gated voice (ties go to
// the lowest index).
module voice_pick
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_W     = 7
) (
  input  logic [NUM_VOICES-1:0]        i_gate,
  input  logic [NUM_VOICES*NOTE_W-1:0] i_note,
  input  logic [NUM_VOICES*AGE_W-1:0]  i_age,
  input  logic [NOTE_W-1:0]            i_key,
  output logic [IDX_W-1:0]             o_match_idx,
  output logic                         o_match_hit,
  output logic [IDX_W-1:0]             o_free_idx,
  output logic                         o_free_any,
  output logic [IDX_W-1:0]             o_old_idx
);

  logic [AGE_W-1:0] w_old_age;
  logic             w_old_any;

  // First gated voice holding the incoming note.
  always_comb begin
    o_match_idx = '0;
    o_match_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!o_match_hit && i_gate[i] && (i_note[i*NOTE_W +: NOTE_W] == i_key)) begin
        o_match_hit = 1'b1;
        o_match_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index voice that is not gated.
  always_comb begin
    o_free_idx = '0;
    o_free_any = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!o_free_any && !i_gate[i]) begin
        o_free_any = 1'b1;
        o_free_idx = IDX_W'(i);
      end
    end
  end

  // Gated voice with the largest age; strict compare keeps the lowest index on ties.
  always_comb begin
    o_old_idx = '0;
    w_old_age = '0;
    w_old_any = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (i_gate[i] && (!w_old_any || (i_age[i*AGE_W +: AGE_W] > w_old_age))) begin
        w_old_any = 1'b1;
        w_old_age = i_age[i*AGE_W +: AGE_W];
        o_old_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Note-command decoder and polyphonic voice allocator. Each Avalon write is
// decoded and applied in the cycle it is sampled; per-voice gate/note/vel and
// the one-cycle trig/rel strobes are registered (latency 1).
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned NOTE_W       = 7,
  parameter int unsigned VEL_W        = 8,
  parameter int unsigned STEAL_OLDEST = 1,
  parameter int unsigned STOP_ALL_N   = synth_pkg::STOP_ALL_N
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         avs_s0_write,
  input  logic [31:0]                  avs_s0_writedata,
  input  logic                         avs_s0_read,
  output logic [31:0]                  avs_s0_readdata,
  output logic [NUM_VOICES-1:0]        o_voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] o_voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  o_voice_vel,
  output logic [NUM_VOICES-1:0]        o_voice_trig,
  output logic [NUM_VOICES-1:0]        o_voice_rel
);

  logic [NUM_VOICES-1:0]        r_gate;
  logic [NUM_VOICES*NOTE_W-1:0] r_note;
  logic [NUM_VOICES*VEL_W-1:0]  r_vel;
  logic [NUM_VOICES*AGE_W-1:0]  r_age;
  logic [NUM_VOICES-1:0]        r_trig;
  logic [NUM_VOICES-1:0]        r_rel;
  logic [15:0]                  r_drop;
  logic [31:0]                  r_readdata;

  logic [NUM_VOICES-1:0]        w_gate_n;
  logic [NUM_VOICES*NOTE_W-1:0] w_note_n;
  logic [NUM_VOICES*VEL_W-1:0]  w_vel_n;
  logic [NUM_VOICES*AGE_W-1:0]  w_age_n;
  logic [NUM_VOICES-1:0]        w_trig_n;
  logic [NUM_VOICES-1:0]        w_rel_n;
  logic [15:0]                  w_drop_n;
  logic [15:0]                  w_mask16;

  logic                         w_on;
  logic [NOTE_W-1:0]            w_key;
  logic [VEL_W-1:0]             w_vel;
  cmd_e                         w_cmd;
  logic                         w_unused;

  logic [IDX_W-1:0]             w_match_idx;
  logic                         w_match_hit;
  logic [IDX_W-1:0]             w_free_idx;
  logic                         w_free_any;
  logic [IDX_W-1:0]             w_old_idx;
  logic [IDX_W-1:0]             w_tgt;
  logic                         w_load;

  assign w_on     = avs_s0_writedata[ON_BIT];
  assign w_key    = avs_s0_writedata[NOTE_LSB +: NOTE_W];
  assign w_vel    = avs_s0_writedata[VEL_LSB +: VEL_W];
  assign w_unused = ^avs_s0_writedata[31:16];

  voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W)
  ) u_pick (
    .i_gate      (r_gate),
    .i_note      (r_note),
    .i_age       (r_age),
    .i_key       (w_key),
    .o_match_idx (w_match_idx),
    .o_match_hit (w_match_hit),
    .o_free_idx  (w_free_idx),
    .o_free_any  (w_free_any),
    .o_old_idx   (w_old_idx)
  );

  // Classify the sampled write; note-off on STOP_ALL_N is the only special case.
  always_comb begin
    w_cmd = CMD_NONE;
    if (avs_s0_write) begin
      if (w_on)                               w_cmd = CMD_ON;
      else if (w_key == NOTE_W'(STOP_ALL_N))  w_cmd = CMD_STOP_ALL;
      else                                    w_cmd = CMD_OFF;
    end
  end

  // Next voice state for the decoded command.
  always_comb begin
    w_gate_n = r_gate;
    w_note_n = r_note;
    w_vel_n  = r_vel;
    w_age_n  = r_age;
    w_trig_n = '0;
    w_rel_n  = '0;
    w_drop_n = r_drop;
    w_tgt    = w_free_any ? w_free_idx : w_old_idx;
    w_load   = 1'b0;

    unique case (w_cmd)
      CMD_ON: begin
        if (w_match_hit) begin
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == w_match_idx) begin
              w_vel_n[i*VEL_W +: VEL_W] = w_vel;
              w_trig_n[i]               = 1'b1;
            end
          end
        end else if (w_free_any || (STEAL_OLDEST != 0)) begin
          w_load = 1'b1;
        end else if (r_drop != 16'hFFFF) begin
          w_drop_n = r_drop + 16'd1;
        end
      end
      CMD_OFF: begin
        if (w_match_hit) begin
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == w_match_idx) begin
              w_gate_n[i] = 1'b0;
              w_rel_n[i]  = 1'b1;
            end
          end
        end
      end
      CMD_STOP_ALL: begin
        w_gate_n = '0;
        w_rel_n  = r_gate;
      end
      default: ;
    endcase

    // A fresh or stolen voice starts at age 0 and every other sounding voice grows older.
    if (w_load) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == w_tgt) begin
          w_gate_n[i]                 = 1'b1;
          w_note_n[i*NOTE_W +: NOTE_W] = w_key;
          w_vel_n[i*VEL_W +: VEL_W]    = w_vel;
          w_age_n[i*AGE_W +: AGE_W]    = '0;
          w_trig_n[i]                 = 1'b1;
        end else if (r_gate[i]) begin
          w_age_n[i*AGE_W +: AGE_W] = age_inc(r_age[i*AGE_W +: AGE_W], AGE_W'(NUM_VOICES - 1));
        end
      end
    end
  end

  // Status word is built from post-write state so a same-cycle read sees the write.
  always_comb begin
    w_mask16                 = '0;
    w_mask16[NUM_VOICES-1:0] = w_gate_n;
  end

  // Voice state registers; reset overrides any same-cycle command.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate <= '0;
      r_note <= '0;
      r_vel  <= '0;
      r_age  <= '0;
      r_trig <= '0;
      r_rel  <= '0;
      r_drop <= '0;
    end else begin
      r_gate <= w_gate_n;
      r_note <= w_note_n;
      r_vel  <= w_vel_n;
      r_age  <= w_age_n;
      r_trig <= w_trig_n;
      r_rel  <= w_rel_n;
      r_drop <= w_drop_n;
    end
  end

  // Read data capture; holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (avs_s0_read) begin
      r_readdata <= {w_drop_n, w_mask16};
    end
  end

  assign avs_s0_readdata = r_readdata;
  assign o_voice_gate    = r_gate;
  assign o_voice_note    = r_note;
  assign o_voice_vel     = r_vel;
  assign o_voice_trig    = r_trig;
  assign o_voice_rel     = r_rel;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench: two allocators (steal and drop variants) share stimulus;
// a reference model pushes expected post-cycle state, a monitor pops and compares.
module tb_voice_allocator;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_s0_write = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic [31:0] avs_s0_writedata = '0;

  logic [31:0]     rd_s, rd_d;
  logic [NV-1:0]   gate_s, gate_d, trig_s, trig_d, rel_s, rel_d;
  logic [NV*7-1:0] note_s, note_d;
  logic [NV*8-1:0] vel_s, vel_d;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES(NV), .NOTE_W(7), .VEL_W(8), .STEAL_OLDEST(1), .STOP_ALL_N(127)
  ) u_steal (
    .clk(clk), .reset(reset), .avs_s0_write(avs_s0_write), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_read(avs_s0_read), .avs_s0_readdata(rd_s), .o_voice_gate(gate_s),
    .o_voice_note(note_s), .o_voice_vel(vel_s), .o_voice_trig(trig_s), .o_voice_rel(rel_s)
  );

  voice_allocator #(
    .NUM_VOICES(NV), .NOTE_W(7), .VEL_W(8), .STEAL_OLDEST(0), .STOP_ALL_N(127)
  ) u_drop (
    .clk(clk), .reset(reset), .avs_s0_write(avs_s0_write), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_read(avs_s0_read), .avs_s0_readdata(rd_d), .o_voice_gate(gate_d),
    .o_voice_note(note_d), .o_voice_vel(vel_d), .o_voice_trig(trig_d), .o_voice_rel(rel_d)
  );

  typedef struct packed {
    logic [NV-1:0]   gate;
    logic [NV*7-1:0] note;
    logic [NV*8-1:0] vel;
    logic [NV-1:0]   trig;
    logic [NV-1:0]   rel;
    logic [31:0]     rd;
  } exp_t;

  exp_t q_s[$];
  exp_t q_d[$];

  // Reference state: index 0 = steal variant, 1 = drop variant.
  int          m_gate[2][NV];
  int          m_note[2][NV];
  int          m_vel [2][NV];
  int          m_age [2][NV];
  int          m_drop[2];
  logic [31:0] m_rd  [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_step(input bit rst, input bit wr, input bit rd, input logic [31:0] wd);
    exp_t        e;
    int          hit, tgt, on, n, v;
    logic [7:0]  tr, rl, gbits;
    logic [31:0] dtmp;
    for (int m = 0; m < 2; m++) begin
      tr = '0; rl = '0;
      on = int'(wd[15]); n = int'(wd[14:8]); v = int'(wd[7:0]);
      if (rst) begin
        for (int i = 0; i < NV; i++) begin
          m_gate[m][i] = 0; m_note[m][i] = 0; m_vel[m][i] = 0; m_age[m][i] = 0;
        end
        m_drop[m] = 0;
        m_rd[m]   = '0;
      end else begin
        if (wr) begin
          hit = -1;
          for (int i = 0; i < NV; i++)
            if (m_gate[m][i] != 0 && m_note[m][i] == n) hit = i;
          if (on != 0) begin
            if (hit >= 0) begin
              m_vel[m][hit] = v;
              tr[hit] = 1'b1;
            end else begin
              tgt = -1;
              for (int i = NV - 1; i >= 0; i--)
                if (m_gate[m][i] == 0) tgt = i;
              if (tgt < 0 && m == 0) begin
                tgt = 0;
                for (int i = 1; i < NV; i++)
                  if (m_age[m][i] > m_age[m][tgt]) tgt = i;
              end
              if (tgt >= 0) begin
                for (int i = 0; i < NV; i++)
                  if (i != tgt && m_gate[m][i] != 0 && m_age[m][i] < NV - 1)
                    m_age[m][i] = m_age[m][i] + 1;
                m_gate[m][tgt] = 1; m_note[m][tgt] = n; m_vel[m][tgt] = v; m_age[m][tgt] = 0;
                tr[tgt] = 1'b1;
              end else if (m_drop[m] < 65535) begin
                m_drop[m] = m_drop[m] + 1;
              end
            end
          end else if (n == 127) begin
            for (int i = 0; i < NV; i++) begin
              rl[i] = (m_gate[m][i] != 0);
              m_gate[m][i] = 0;
            end
          end else if (hit >= 0) begin
            m_gate[m][hit] = 0;
            rl[hit] = 1'b1;
          end
        end
        if (rd) begin
          for (int i = 0; i < NV; i++) gbits[i] = (m_gate[m][i] != 0);
          dtmp = m_drop[m];
          m_rd[m] = {dtmp[15:0], 8'h00, gbits};
        end
      end
      for (int i = 0; i < NV; i++) begin
        e.gate[i]       = (m_gate[m][i] != 0);
        e.note[i*7 +: 7] = 7'(m_note[m][i]);
        e.vel[i*8 +: 8]  = 8'(m_vel[m][i]);
      end
      e.trig = tr;
      e.rel  = rl;
      e.rd   = m_rd[m];
      if (m == 0) q_s.push_back(e);
      else        q_d.push_back(e);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input bit rd, input logic [31:0] wd);
    @(negedge clk);
    reset            = rst;
    avs_s0_write     = wr;
    avs_s0_read      = rd;
    avs_s0_writedata = wd;
    model_step(rst, wr, rd, wd);
  endtask

  function automatic logic [31:0] cmd(input bit on, input int note, input int vel);
    logic [31:0] w;
    w        = '0;
    w[31:16] = 16'($urandom);
    w[15]    = on;
    w[14:8]  = 7'(note);
    w[7:0]   = 8'(vel);
    return w;
  endfunction

  task automatic wcmd(input bit on, input int note, input int vel, input bit rd);
    step(1'b0, 1'b1, rd, cmd(on, note, vel));
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, rd, 32'($urandom));
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, one expectation per sampled edge.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      check("steal.gate", 64'(gate_s), 64'(e.gate));
      check("steal.note", 64'(note_s), 64'(e.note));
      check("steal.vel",  vel_s,       e.vel);
      check("steal.trig", 64'(trig_s), 64'(e.trig));
      check("steal.rel",  64'(rel_s),  64'(e.rel));
      check("steal.rd",   64'(rd_s),   64'(e.rd));
    end
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      check("drop.gate", 64'(gate_d), 64'(e.gate));
      check("drop.note", 64'(note_d), 64'(e.note));
      check("drop.vel",  vel_d,       e.vel);
      check("drop.trig", 64'(trig_d), 64'(e.trig));
      check("drop.rel",  64'(rel_d),  64'(e.rel));
      check("drop.rd",   64'(rd_d),   64'(e.rd));
    end
  end

  initial begin
    int r;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);

    // First note after reset
    wcmd(1'b1, 36, 'h40, 1'b0);
    idle(1'b0); idle(1'b0);

    // On/off sequence with read of active mask
    step(1'b1, 1'b0, 1'b0, '0);
    wcmd(1'b1, 36, 'h11, 1'b0);
    wcmd(1'b1, 41, 'h22, 1'b0);
    wcmd(1'b0, 36, 'h00, 1'b0);
    wcmd(1'b1, 60, 'h33, 1'b1);
    idle(1'b0);

    // Retrigger
    step(1'b1, 1'b0, 1'b0, '0);
    wcmd(1'b1, 41, 'h20, 1'b0);
    wcmd(1'b1, 41, 'h10, 1'b0);
    idle(1'b0);

    // Fill all voices then one more note-on
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 20; k < 28; k++) wcmd(1'b1, k, k, 1'b0);
    wcmd(1'b1, 90, 'h55, 1'b1);
    idle(1'b0);

    // Note-off for a silent note, then stop-all with five voices on
    wcmd(1'b0, 99, 'h7F, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) wcmd(1'b1, 50 + k, 'h40, 1'b0);
    wcmd(1'b0, 127, 'h00, 1'b1);
    idle(1'b0);

    // Reset mid-sequence, colliding with a write and a read
    for (int k = 0; k < 3; k++) wcmd(1'b1, 70 + k, 'h01, 1'b0);
    step(1'b1, 1'b1, 1'b1, cmd(1'b1, 80, 'h02));
    idle(1'b1);

    // Randomized traffic over a narrow note range to exercise hits, fills and steals
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        step(1'b1, 1'b0, 1'($urandom), '0);
      end else if (r < 150) begin
        int nt;
        nt = ($urandom_range(0, 19) == 0) ? 127 : int'($urandom_range(20, 31));
        wcmd(1'($urandom_range(0, 9) < 6), nt, int'($urandom_range(0, 255)),
             1'($urandom_range(0, 2) == 0));
      end else begin
        idle(1'($urandom));
      end
    end

    idle(1'b0);
    for (int k = 0; k < 10 && (q_s.size() > 0 || q_d.size() > 0); k++) @(negedge clk);
    n_tests++;
    if (q_s.size() > 0 || q_d.size() > 0) begin
      n_fail++;
      $display("FAIL drain: queues got %0d/%0d entries expected 0/0", q_s.size(), q_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
